// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipeline register chain
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_DEPTH = 64;

  function automatic logic [7:0] popcount(input logic [MAX_DEPTH-1:0] mask);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + {7'd0, mask[i]};
    end
    return n;
  endfunction

  // Adds inc to cnt, clamping at the largest value representable in w bits (w <= 63).
  function automatic logic [63:0] sat_add(input logic [63:0] cnt, input logic [63:0] inc,
                                          input int w);
    logic [63:0] max_v;
    logic [64:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = {1'b0, cnt} + {1'b0, inc};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one pipeline register stage with kill, hold and bubble zeroing
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             stall,
  input  logic             kill,
  output logic             valid,
  output logic             eff_valid,
  output logic [WIDTH-1:0] data
);

  logic             next_valid;
  logic [WIDTH-1:0] next_data;

  // Killed occupant looks invalid both to this stage's hold path and to the stage downstream.
  assign eff_valid = valid & ~kill;

  always_comb begin
    next_valid = stall ? eff_valid : up_valid;
    next_data  = stall ? data : up_data;
    if (ZERO_BUBBLE && !next_valid) begin
      next_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= next_valid;
      data  <= next_data;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised pipeline register chain with stall/flush and counters
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = 1,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             stall_i,
  input  logic [DEPTH-1:0] flush_i,
  input  logic             cnt_clr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [DEPTH-1:0] stage_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] kill_cnt_o
);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] eff_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_first
      assign up_valid = valid_i;
      assign up_data  = data_i;
    end else begin : g_rest
      assign up_valid = eff_valid[k-1];
      assign up_data  = stage_data[k-1];
    end

    pipe_stage_cell #(
      .WIDTH      (WIDTH),
      .ZERO_BUBBLE(ZERO_BUBBLE)
    ) u_cell (
      .clk      (clk_i),
      .rst      (rst_i),
      .up_valid (up_valid),
      .up_data  (up_data),
      .stall    (stall_i),
      .kill     (flush_i[k]),
      .valid    (stage_valid[k]),
      .eff_valid(eff_valid[k]),
      .data     (stage_data[k])
    );
  end

  assign valid_o       = stage_valid[DEPTH-1];
  assign data_o        = stage_data[DEPTH-1];
  assign stage_valid_o = stage_valid;

  logic [CNT_W-1:0] stall_next;
  logic [CNT_W-1:0] kill_next;

  // Only words that were actually valid before the edge count as destroyed.
  assign stall_next = CNT_W'(sat_add(64'(stall_cnt_o), {63'd0, stall_i}, CNT_W));
  assign kill_next  = CNT_W'(sat_add(64'(kill_cnt_o),
                                     {56'd0, popcount(MAX_DEPTH'(flush_i & stage_valid))}, CNT_W));

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_o <= '0;
      kill_cnt_o  <= '0;
    end else begin
      stall_cnt_o <= stall_next;
      kill_cnt_o  <= kill_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst;

  logic        valid_i;
  logic [31:0] data_i;
  logic        stall;
  logic [2:0]  flush;
  logic        cnt_clr;
  logic        valid_o;
  logic [31:0] data_o;
  logic [2:0]  stage_valid;
  logic [3:0]  stall_cnt;
  logic [3:0]  kill_cnt;

  logic        v1_i;
  logic [7:0]  d1_i;
  logic        stall1;
  logic [0:0]  flush1;
  logic        clr1;
  logic        v1_o;
  logic [7:0]  d1_o;
  logic [0:0]  sv1;
  logic [3:0]  stall_cnt1;
  logic [3:0]  kill_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .WIDTH(32), .DEPTH(3), .ZERO_BUBBLE(1'b1), .CNT_W(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .stall_i      (stall),
    .flush_i      (flush),
    .cnt_clr_i    (cnt_clr),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .stage_valid_o(stage_valid),
    .stall_cnt_o  (stall_cnt),
    .kill_cnt_o   (kill_cnt)
  );

  pipe_stage_chain #(
    .WIDTH(8), .DEPTH(1), .ZERO_BUBBLE(1'b0), .CNT_W(4)
  ) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (v1_i),
    .data_i       (d1_i),
    .stall_i      (stall1),
    .flush_i      (flush1),
    .cnt_clr_i    (clr1),
    .valid_o      (v1_o),
    .data_o       (d1_o),
    .stage_valid_o(sv1),
    .stall_cnt_o  (stall_cnt1),
    .kill_cnt_o   (kill_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b1; data_i = 32'h77; stall = 1'b1; flush = 3'b111; cnt_clr = 1'b0;
    v1_i = 1'b1; d1_i = 8'h66; stall1 = 1'b1; flush1 = 1'b1; clr1 = 1'b0;
    step(); step();
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_stage_valid", 64'(stage_valid), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_kill_cnt", 64'(kill_cnt), 64'd0);
    check("rst_d1_valid", 64'(v1_o), 64'd0);

    rst = 1'b0; valid_i = 1'b0; data_i = '0; stall = 1'b0; flush = '0;
    stall1 = 1'b0; flush1 = 1'b0;

    // DEPTH=1, ZERO_BUBBLE=0 instance
    v1_i = 1'b1; d1_i = 8'h5A; step();
    check("d1_latency_valid", 64'(v1_o), 64'd1);
    check("d1_latency_data", 64'(d1_o), 64'h5A);
    v1_i = 1'b0; d1_i = 8'h00; stall1 = 1'b1; flush1 = 1'b1; step();
    check("d1_kill_stall_valid", 64'(v1_o), 64'd0);
    check("d1_kill_stall_data_kept", 64'(d1_o), 64'h5A);
    check("d1_kill_cnt", 64'(kill_cnt1), 64'd1);
    check("d1_stall_cnt", 64'(stall_cnt1), 64'd1);
    stall1 = 1'b0; flush1 = 1'b1; d1_i = 8'h3C; step();
    check("d1_bubble_data_captured", 64'(d1_o), 64'h3C);
    check("d1_flush_invalid_no_count", 64'(kill_cnt1), 64'd1);
    flush1 = 1'b0;

    // Streaming latency and throughput
    valid_i = 1'b1; data_i = 32'h11; step();
    check("stream_sv1", 64'(stage_valid), 64'b001);
    data_i = 32'h22; step();
    check("stream_valid_o_early", 64'(valid_o), 64'd0);
    check("stream_sv2", 64'(stage_valid), 64'b011);
    data_i = 32'h33; step();
    check("stream_valid_o", 64'(valid_o), 64'd1);
    check("stream_data_11", 64'(data_o), 64'h11);
    data_i = 32'h44; step();
    check("stream_data_22", 64'(data_o), 64'h22);

    // Stall freezes the chain
    stall = 1'b1; data_i = 32'h99; step(); step();
    check("stall_data_frozen", 64'(data_o), 64'h22);
    check("stall_sv_frozen", 64'(stage_valid), 64'b111);
    check("stall_cnt_2", 64'(stall_cnt), 64'd2);
    stall = 1'b0; valid_i = 1'b0; data_i = '0; step();
    check("resume_33", 64'(data_o), 64'h33);
    step();
    check("resume_44", 64'(data_o), 64'h44);
    step();
    check("drain_valid_o", 64'(valid_o), 64'd0);
    check("drain_data_zero", 64'(data_o), 64'd0);

    // Flush middle stage without stall
    cnt_clr = 1'b1; valid_i = 1'b1; data_i = 32'hC; step();
    check("clr_stall_cnt", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0; data_i = 32'hB; step();
    data_i = 32'hA; step();
    check("loaded_sv", 64'(stage_valid), 64'b111);
    check("loaded_data_o", 64'(data_o), 64'hC);
    flush = 3'b010; data_i = 32'hD; step();
    check("flush_mid_sv", 64'(stage_valid), 64'b011);
    check("flush_mid_data_zero", 64'(data_o), 64'd0);
    check("flush_mid_kill_cnt", 64'(kill_cnt), 64'd1);

    // Flush stages 0 and 2 during stall
    flush = 3'b000; cnt_clr = 1'b1; data_i = 32'hC; step();
    cnt_clr = 1'b0; data_i = 32'hB; step();
    data_i = 32'hA; step();
    check("reload_kill_cnt", 64'(kill_cnt), 64'd0);
    stall = 1'b1; flush = 3'b101; data_i = 32'hE; step();
    check("stall_flush_sv", 64'(stage_valid), 64'b010);
    check("stall_flush_data_o", 64'(data_o), 64'd0);
    check("stall_flush_kill_cnt", 64'(kill_cnt), 64'd2);
    check("stall_flush_stall_cnt", 64'(stall_cnt), 64'd1);
    stall = 1'b0; flush = 3'b000; valid_i = 1'b0; data_i = '0; step();
    check("held_B_valid_o", 64'(valid_o), 64'd1);
    check("held_B_data_o", 64'(data_o), 64'hB);
    check("held_B_sv", 64'(stage_valid), 64'b100);

    // Flush on invalid stages
    flush = 3'b011; step();
    check("flush_invalid_kill_cnt", 64'(kill_cnt), 64'd2);
    check("flush_invalid_sv", 64'(stage_valid), 64'b000);
    flush = 3'b000;

    // Counter saturation and clear-beats-increment
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("stall_cnt_sat", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1; step();
    check("clr_vs_stall_stall_cnt", 64'(stall_cnt), 64'd0);
    check("clr_vs_stall_kill_cnt", 64'(kill_cnt), 64'd0);
    cnt_clr = 1'b0; stall = 1'b0;

    // Flush all during stall
    valid_i = 1'b1; data_i = 32'h1; step();
    data_i = 32'h2; step();
    data_i = 32'h3; step();
    stall = 1'b1; flush = 3'b111; step();
    check("flush_all_sv", 64'(stage_valid), 64'b000);
    check("flush_all_kill_cnt", 64'(kill_cnt), 64'd3);
    check("flush_all_data_o", 64'(data_o), 64'd0);

    // Mid-stream reset beats stall and flush
    stall = 1'b0; flush = 3'b000; data_i = 32'h4; step();
    data_i = 32'h5; step();
    data_i = 32'h6; step();
    flush = 3'b001; data_i = 32'h7; step();
    check("pre_rst_kill_cnt", 64'(kill_cnt), 64'd4);
    check("pre_rst_data_o", 64'(data_o), 64'h5);
    check("pre_rst_sv", 64'(stage_valid), 64'b101);
    rst = 1'b1; stall = 1'b1; flush = 3'b111; data_i = 32'h8; step();
    check("mid_rst_sv", 64'(stage_valid), 64'd0);
    check("mid_rst_valid_o", 64'(valid_o), 64'd0);
    check("mid_rst_data_o", 64'(data_o), 64'd0);
    check("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("mid_rst_kill_cnt", 64'(kill_cnt), 64'd0);
    rst = 1'b0; stall = 1'b0; flush = 3'b000; valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
